seg7_capture: RTL
=================

SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 3: maximum digits per frame before overflow.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port seg, input, 7: segment pattern {a,b,c,d,e,f,g}, active-low (0 = lit).
REQ-005 SHALL have port seg_valid, input, 1: seg carries a digit beat.
REQ-006 SHALL have port seg_last, input, 1: the current beat is the final (least-significant) digit of the frame.
REQ-007 SHALL have port seg_ready, output, 1: block accepts a beat this cycle.
REQ-008 SHALL have port out_value, output, 8: decoded binary result.
REQ-009 SHALL have port out_valid, output, 1: result pending.
REQ-010 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-011 SHALL have port out_err, output, 1: frame contained an unrecognised pattern.
REQ-012 SHALL have port out_ovr, output, 1: frame contained the dash pattern (source out of range).
REQ-013 SHALL have port out_ovf, output, 1: value exceeded 255 or digit count exceeded MAX_DIGITS.

Function
REQ-014 SHALL decode the active-low patterns as follows: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0001100=9, 1111110=dash; all other patterns SHALL decode as bad.
REQ-015 SHALL accept a beat only when seg_valid and seg_ready are both high.
REQ-016 SHALL have states IDLE (no digits yet), ACCUM (at least one digit accepted) and HOLD (result pending).
REQ-017 SHALL drive seg_ready high in IDLE and ACCUM, and low in HOLD.
REQ-018 SHALL, on each accepted digit beat, update acc to acc*10 + digit, using an internal width of at least 12 bits.
REQ-019 SHALL set the sticky ovf flag when acc exceeds 255 or when the accepted digit count exceeds MAX_DIGITS; acc SHALL then stop updating.
REQ-020 SHALL, on an accepted dash beat, set the sticky ovr flag and leave acc unchanged.
REQ-021 SHALL, on an accepted bad beat, set the sticky err flag and leave acc unchanged.
REQ-022 SHALL count dash and bad beats toward the digit count.
REQ-023 SHALL transition IDLE->ACCUM on an accepted beat with seg_last low.
REQ-024 SHALL transition IDLE->HOLD or ACCUM->HOLD on an accepted beat with seg_last high, including that beat in the result.
REQ-025 SHALL assert out_valid in the cycle after the last beat is accepted (latency 1) and hold it until out_ready is high.
REQ-026 SHALL keep out_value and all flags stable while out_valid is high.
REQ-027 SHALL drive out_value = 255 when ovf is set, otherwise acc[7:0].
REQ-028 SHALL drive out_value = 0 when err or ovr is set and no valid digits were accepted.
REQ-029 SHALL, on out_valid and out_ready both high, go HOLD->IDLE and clear acc, count and flags; seg_ready SHALL be high in the following cycle.
REQ-030 SHALL not accept a new beat in the same cycle as the out_valid/out_ready handshake.
REQ-031 SHALL keep out_value, out_err, out_ovr and out_ovf at 0 whenever out_valid is low.

Reset
REQ-032 SHALL, on rst high at a clock edge, enter IDLE and clear acc, count and all flags.
REQ-033 SHALL drive outputs after reset as: out_valid=0, out_value=0, out_err=0, out_ovr=0, out_ovf=0, seg_ready=1.
REQ-034 SHALL discard any partial frame or pending result when rst is asserted mid-operation.
REQ-035 SHALL give rst priority over all simultaneous events.

Structure
REQ-036 SHALL place the ten digit pattern constants, the dash pattern and the state enum in shared package seg7_pkg.
REQ-037 SHALL implement the pattern-to-{digit, is_dash, is_bad} decode as combinational sub-module seg7_digit_decode.
REQ-038 SHALL contain no latches and no combinational path from seg to out_*.

Verification
REQ-039 Beats 2, 5, 5 (last on the third) -> out_valid one cycle later; out_value=255; err, ovr and ovf all 0.
REQ-040 Beats 2, 5, 6 -> out_value=255, ovf=1; beats 0, 0, 1, 2 -> ovf=1 (4 digits), out_value=255.
REQ-041 Beats 4, 1111111, 2 -> err=1; beat 1111110 alone -> ovr=1, out_value=0.
REQ-042 Frame 4, 7 with out_ready low for 5 cycles -> out_value=47 held stable and seg_ready=0 throughout; handshake -> seg_ready=1 next cycle.
REQ-043 rst asserted after beat 9 of a frame -> state IDLE, outputs at reset values; next frame 3 (last) -> out_value=3.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment capture block.
// Patterns are active-low, ordered {a,b,c,d,e,f,g}.
package seg7_pkg;

   localparam int unsigned SEG_W      = 7;
   localparam int unsigned DIGIT_W    = 4;
   localparam int unsigned ACC_W      = 12;
   localparam int unsigned OUT_W      = 8;
   localparam int unsigned NUM_DIGITS = 10;

   localparam logic [SEG_W-1:0] SEG_0    = 7'b0000001;
   localparam logic [SEG_W-1:0] SEG_1    = 7'b1001111;
   localparam logic [SEG_W-1:0] SEG_2    = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_3    = 7'b0000110;
   localparam logic [SEG_W-1:0] SEG_4    = 7'b1001100;
   localparam logic [SEG_W-1:0] SEG_5    = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_6    = 7'b0100000;
   localparam logic [SEG_W-1:0] SEG_7    = 7'b0001111;
   localparam logic [SEG_W-1:0] SEG_8    = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9    = 7'b0001100;
   localparam logic [SEG_W-1:0] SEG_DASH = 7'b1111110;

   localparam logic [SEG_W-1:0] SEG_DIGITS [NUM_DIGITS] = '{
      SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7, SEG_8, SEG_9
   };

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   typedef struct packed {
      logic [DIGIT_W-1:0] digit;
      logic               is_dash;
      logic               is_bad;
   } seg_dec_t;

   typedef struct packed {
      logic err;
      logic ovr;
      logic ovf;
   } flags_t;

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational decode of one active-low segment pattern into digit / dash / bad.
module seg7_digit_decode
   import seg7_pkg::*;
(
   input  logic [SEG_W-1:0] seg,
   output seg_dec_t         dec_c
);

   always_comb begin : decode
      dec_c        = '0;
      dec_c.is_bad = 1'b1;
      if (seg == SEG_DASH) begin
         dec_c.is_dash = 1'b1;
         dec_c.is_bad  = 1'b0;
      end
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (seg == SEG_DIGITS[i]) begin
            dec_c.digit  = DIGIT_W'(i);
            dec_c.is_bad = 1'b0;
         end
      end
   end

endmodule

// File: rtl/seg7_capture.sv
// Collects a frame of seven-segment digit beats into a binary value with
// error/out-of-range/overflow flags, presented on a valid/ready result port.
module seg7_capture
   import seg7_pkg::*;
#(
   parameter int unsigned MAX_DIGITS = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SEG_W-1:0] seg,
   input  logic             seg_valid,
   input  logic             seg_last,
   output logic             seg_ready,
   output logic [OUT_W-1:0] out_value,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_err,
   output logic             out_ovr,
   output logic             out_ovf
);

   localparam int unsigned      CNT_W     = $clog2(MAX_DIGITS + 2);
   localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_DIGITS);
   localparam logic [OUT_W-1:0] OUT_SAT   = '1;
   localparam logic [ACC_W-1:0] ACC_LIMIT = ACC_W'(OUT_SAT);
   localparam logic [ACC_W-1:0] TEN       = ACC_W'(10);

   state_t             state, state_next;
   logic [ACC_W-1:0]   acc, acc_next, acc_calc, beat_acc;
   logic [CNT_W-1:0]   count, count_next, count_inc, beat_count;
   flags_t             flags, flags_next, beat_flags;
   flags_t             out_flags, out_flags_next;
   logic [OUT_W-1:0]   out_value_next;
   logic               out_valid_next;
   logic               seg_ready_next;
   seg_dec_t           dec_c;

   seg7_digit_decode u_decode (
      .seg   (seg),
      .dec_c (dec_c)
   );

   // Effect of accepting the current beat on the accumulator, count and flags.
   always_comb begin : beat_update
      count_inc  = count + CNT_W'(1);
      acc_calc   = (acc * TEN) + ACC_W'(dec_c.digit);
      beat_acc   = acc;
      beat_count = count;
      beat_flags = flags;
      if (!flags.ovf) begin
         beat_count = count_inc;
         if (count_inc > MAX_CNT) begin
            beat_flags.ovf = 1'b1;
         end else if (!dec_c.is_dash && !dec_c.is_bad) begin
            if (acc_calc > ACC_LIMIT) begin
               beat_flags.ovf = 1'b1;
            end else begin
               beat_acc = acc_calc;
            end
         end
      end
      if (dec_c.is_dash) begin
         beat_flags.ovr = 1'b1;
      end
      if (dec_c.is_bad) begin
         beat_flags.err = 1'b1;
      end
   end

   always_comb begin : fsm_next
      state_next     = state;
      acc_next       = acc;
      count_next     = count;
      flags_next     = flags;
      out_valid_next = out_valid;
      out_value_next = out_value;
      out_flags_next = out_flags;
      unique case (state)
         S_IDLE, S_ACCUM: begin
            if (seg_valid) begin
               acc_next   = beat_acc;
               count_next = beat_count;
               flags_next = beat_flags;
               if (seg_last) begin
                  state_next     = S_HOLD;
                  out_valid_next = 1'b1;
                  out_value_next = beat_flags.ovf ? OUT_SAT : beat_acc[OUT_W-1:0];
                  out_flags_next = beat_flags;
               end else begin
                  state_next = S_ACCUM;
               end
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               state_next     = S_IDLE;
               acc_next       = '0;
               count_next     = '0;
               flags_next     = '0;
               out_valid_next = 1'b0;
               out_value_next = '0;
               out_flags_next = '0;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
      seg_ready_next = (state_next != S_HOLD);
   end

   always_ff @(posedge clk) begin : regs
      if (rst) begin
         state     <= S_IDLE;
         acc       <= '0;
         count     <= '0;
         flags     <= '0;
         seg_ready <= 1'b1;
         out_valid <= 1'b0;
         out_value <= '0;
         out_flags <= '0;
      end else begin
         state     <= state_next;
         acc       <= acc_next;
         count     <= count_next;
         flags     <= flags_next;
         seg_ready <= seg_ready_next;
         out_valid <= out_valid_next;
         out_value <= out_value_next;
         out_flags <= out_flags_next;
      end
   end

   assign out_err = out_flags.err;
   assign out_ovr = out_flags.ovr;
   assign out_ovf = out_flags.ovf;

endmodule
